complex_divider_seq: RTL and testbench

//  Iterative signed complex divider, the inverse of the team's 8+8-bit complex multiplier.

---
 rtl/cdiv_pkg.sv | 12 +
 rtl/complex_divider_seq_serial_udiv.sv | 51 +++++
 rtl/complex_divider_seq.sv | 179 +++++++++++++++++
 tb/tb_complex_divider_seq.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cdiv_pkg.sv
// Shared types and widths for the iterative complex divider.
package cdiv_pkg;
    typedef enum logic [1:0] {IDLE, PREP, DIV, FIN} state_t;

    localparam int PART_W = 8;
    localparam int NUM_W  = 17;
    localparam int DEN_W  = 16;

    function automatic int q_bits(input int frac);
        return 2 * PART_W + frac;
    endfunction
endpackage

// File: rtl/complex_divider_seq_serial_udiv.sv
// Unsigned restoring divider, one quotient bit per step, MSB first.
// The dividend register shifts out as the quotient shifts in.
module serial_udiv #(
    parameter int N_W = 24,
    parameter int D_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           load,
    input  logic           step,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic [N_W-1:0] quotient,
    output logic [D_W-1:0] remainder
);
    logic [N_W-1:0] quo_q, quo_d;
    logic [D_W-1:0] rem_q, rem_d;
    logic [D_W:0]   trial;

    always_comb begin
        trial = {rem_q, quo_q[N_W-1]};
        rem_d = rem_q;
        quo_d = quo_q;
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
        end else if (step) begin
            // rem < divisor keeps trial inside D_W+1 bits, so the restore path never loses a bit
            if (trial >= {1'b0, divisor}) begin
                rem_d = D_W'(trial - {1'b0, divisor});
                quo_d = {quo_q[N_W-2:0], 1'b1};
            end else begin
                rem_d = D_W'(trial);
                quo_d = {quo_q[N_W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quo_q <= '0;
            rem_q <= '0;
        end else begin
            quo_q <= quo_d;
            rem_q <= rem_d;
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/complex_divider_seq.sv
// Iterative signed complex divider: Q = N / D on packed {Re, Im} 8-bit parts,
// fixed-point quotients with FRAC_BITS fraction bits, Start/Done handshake.
module complex_divider_seq
    import cdiv_pkg::*;
#(
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [15:0]      Dividend,
    input  logic [15:0]      Divisor,
    output logic             Busy,
    output logic             Done,
    output logic [OUT_W-1:0] QuotReal,
    output logic [OUT_W-1:0] QuotImag,
    output logic             DivByZero,
    output logic             Overflow
);
    localparam int QB    = q_bits(FRAC_BITS);
    localparam int CNT_W = $clog2(QB);
    localparam int EW    = QB + OUT_W;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        opn_q, opn_d, opd_q, opd_d;
    logic [DEN_W-1:0]   den_q, den_d;
    logic               negr_q, negr_d, negi_q, negi_d, zero_q, zero_d;
    logic               busy_q, busy_d, done_q, done_d;
    logic               dbz_q, dbz_d, ovf_q, ovf_d;
    logic [OUT_W-1:0]   qr_q, qr_d, qi_q, qi_d;

    logic signed [NUM_W-1:0] ae, be, ce, de, nr, ni;
    logic signed [DEN_W-1:0] cs, ds;
    logic [DEN_W-1:0]        den, magr, magi;
    logic [QB-1:0]           quor, quoi;
    logic [DEN_W-1:0]        rem_unused_re, rem_unused_im;
    logic                    div_load, div_step, ovr, ovi;
    logic [OUT_W-1:0]        vr, vi;

    // Returns {clipped, value}; a negative result may reach -2^(OUT_W-1) without clipping.
    function automatic logic [OUT_W:0] sign_sat(input logic [QB-1:0] mag, input logic neg);
        logic [EW-1:0] m, lim, mn;
        m   = EW'(mag);
        lim = EW'(1) << (OUT_W - 1);
        mn  = -m;
        if (neg) begin
            if (m > lim) sign_sat = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
            else         sign_sat = {1'b0, OUT_W'(mn)};
        end else begin
            if (m >= lim) sign_sat = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
            else          sign_sat = {1'b0, OUT_W'(m)};
        end
    endfunction

    always_comb begin
        ae = NUM_W'($signed(opn_q[15:8]));
        be = NUM_W'($signed(opn_q[7:0]));
        ce = NUM_W'($signed(opd_q[15:8]));
        de = NUM_W'($signed(opd_q[7:0]));
        cs = DEN_W'($signed(opd_q[15:8]));
        ds = DEN_W'($signed(opd_q[7:0]));
        nr = ae * ce + be * de;
        ni = be * ce - ae * de;
        // c*c + d*d peaks at 32768, which is exact as an unsigned 16-bit pattern
        den  = DEN_W'(cs * cs + ds * ds);
        magr = nr[NUM_W-1] ? DEN_W'(-nr) : DEN_W'(nr);
        magi = ni[NUM_W-1] ? DEN_W'(-ni) : DEN_W'(ni);
    end

    assign div_load = (state_q == PREP);
    assign div_step = (state_q == DIV);

    serial_udiv #(.N_W(QB), .D_W(DEN_W)) u_div_re (
        .clk(Clk), .rst_n(Reset), .load(div_load), .step(div_step),
        .dividend({magr, {FRAC_BITS{1'b0}}}), .divisor(den_q),
        .quotient(quor), .remainder(rem_unused_re)
    );

    serial_udiv #(.N_W(QB), .D_W(DEN_W)) u_div_im (
        .clk(Clk), .rst_n(Reset), .load(div_load), .step(div_step),
        .dividend({magi, {FRAC_BITS{1'b0}}}), .divisor(den_q),
        .quotient(quoi), .remainder(rem_unused_im)
    );

    always_comb begin
        {ovr, vr} = sign_sat(quor, negr_q);
        {ovi, vi} = sign_sat(quoi, negi_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opn_d   = opn_q;
        opd_d   = opd_q;
        den_d   = den_q;
        negr_d  = negr_q;
        negi_d  = negi_q;
        zero_d  = zero_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        ovf_d   = ovf_q;
        qr_d    = qr_q;
        qi_d    = qi_q;
        case (state_q)
            IDLE: if (Start) begin
                opn_d   = Dividend;
                opd_d   = Divisor;
                busy_d  = 1'b1;
                state_d = PREP;
            end
            PREP: begin
                den_d  = den;
                negr_d = nr[NUM_W-1];
                negi_d = ni[NUM_W-1];
                zero_d = (den == '0);
                cnt_d  = CNT_W'(QB - 1);
                state_d = (den == '0) ? FIN : DIV;
            end
            DIV: begin
                if (cnt_q == '0) state_d = FIN;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIN: begin
                qr_d    = zero_q ? '0 : vr;
                qi_d    = zero_q ? '0 : vi;
                ovf_d   = !zero_q && (ovr || ovi);
                dbz_d   = zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opn_q   <= '0;
            opd_q   <= '0;
            den_q   <= '0;
            negr_q  <= 1'b0;
            negi_q  <= 1'b0;
            zero_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
            ovf_q   <= 1'b0;
            qr_q    <= '0;
            qi_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opn_q   <= opn_d;
            opd_q   <= opd_d;
            den_q   <= den_d;
            negr_q  <= negr_d;
            negi_q  <= negi_d;
            zero_q  <= zero_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
            ovf_q   <= ovf_d;
            qr_q    <= qr_d;
            qi_q    <= qi_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign QuotReal  = qr_q;
    assign QuotImag  = qi_q;
    assign DivByZero = dbz_q;
    assign Overflow  = ovf_q;
endmodule

// File: tb/tb_complex_divider_seq.sv
// Directed bench for complex_divider_seq: integer-arithmetic model, expectation queue, per-cycle compare.
module tb_complex_divider_seq;
    logic        Clk = 1'b0;
    logic        Reset, Start;
    logic [15:0] Dividend, Divisor;
    logic        Busy, Done, DivByZero, Overflow;
    logic [15:0] QuotReal, QuotImag;

    complex_divider_seq #(.FRAC_BITS(8), .OUT_W(16)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Dividend(Dividend), .Divisor(Divisor),
        .Busy(Busy), .Done(Done), .QuotReal(QuotReal), .QuotImag(QuotImag),
        .DivByZero(DivByZero), .Overflow(Overflow)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [15:0] qr;
        logic [15:0] qi;
        logic        dbz;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t expq[$];
    exp_t last;
    int   vecs = 0;
    int   miss = 0;
    int   cyc  = 0;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [15:0] n, input logic [15:0] d);
        exp_t e;
        int a, b, c, dd, nr, ni, den, q;
        a = $signed(n[15:8]);  b  = $signed(n[7:0]);
        c = $signed(d[15:8]);  dd = $signed(d[7:0]);
        nr = a * c + b * dd;
        ni = b * c - a * dd;
        den = c * c + dd * dd;
        e = '{qr: 16'h0, qi: 16'h0, dbz: 1'b0, ovf: 1'b0, due: 0};
        if (den == 0) begin
            e.dbz = 1'b1;
            return e;
        end
        q = (nr * 256) / den;
        if (q > 32767)  begin q = 32767;  e.ovf = 1'b1; end
        if (q < -32768) begin q = -32768; e.ovf = 1'b1; end
        e.qr = 16'(q);
        q = (ni * 256) / den;
        if (q > 32767)  begin q = 32767;  e.ovf = 1'b1; end
        if (q < -32768) begin q = -32768; e.ovf = 1'b1; end
        e.qi = 16'(q);
        return e;
    endfunction

    // Compare process: reset state, result on Done (with latency), and hold between results.
    always @(negedge Clk) begin
        exp_t e;
        if (Reset !== 1'b1) begin
            vecs++;
            if ({Busy, Done, DivByZero, Overflow, QuotReal, QuotImag} !== 36'h0) begin
                miss++;
                $display("FAIL reset: got busy=%b done=%b re=%h im=%h dbz=%b ovf=%b, want all 0",
                         Busy, Done, QuotReal, QuotImag, DivByZero, Overflow);
            end
        end else if (Done === 1'b1) begin
            vecs++;
            if (expq.size() == 0) begin
                miss++;
                $display("FAIL spurious_done: got Done=1 at edge %0d, want no Done", cyc);
            end else begin
                e = expq.pop_front();
                if (QuotReal !== e.qr || QuotImag !== e.qi || DivByZero !== e.dbz ||
                    Overflow !== e.ovf || cyc != e.due || Busy !== 1'b0) begin
                    miss++;
                    $display("FAIL result: got re=%h im=%h dbz=%b ovf=%b busy=%b edge=%0d, want re=%h im=%h dbz=%b ovf=%b busy=0 edge=%0d",
                             QuotReal, QuotImag, DivByZero, Overflow, Busy, cyc,
                             e.qr, e.qi, e.dbz, e.ovf, e.due);
                end
                last = e;
            end
        end else begin
            vecs++;
            if (QuotReal !== last.qr || QuotImag !== last.qi ||
                DivByZero !== last.dbz || Overflow !== last.ovf) begin
                miss++;
                $display("FAIL hold: got re=%h im=%h dbz=%b ovf=%b at edge %0d, want re=%h im=%h dbz=%b ovf=%b",
                         QuotReal, QuotImag, DivByZero, Overflow, cyc,
                         last.qr, last.qi, last.dbz, last.ovf);
            end
        end
    end

    // All tasks are entered and left 2 time units after a rising edge.
    task automatic push_exp(input exp_t e);
        exp_t x;
        x = e;
        x.due = cyc + 1 + (x.dbz ? 2 : 26);
        expq.push_back(x);
    endtask

    task automatic issue(input logic [15:0] n, input logic [15:0] d, input exp_t e);
        Start = 1'b1; Dividend = n; Divisor = d;
        push_exp(e);
        @(posedge Clk); #2;
        Start = 1'b0;
        Dividend = 16'($urandom); Divisor = 16'($urandom);
    endtask

    task automatic issue_lit(input logic [15:0] n, input logic [15:0] d,
                             input logic [15:0] qr, input logic [15:0] qi,
                             input logic dbz, input logic ovf);
        exp_t m, lit;
        m = model(n, d);
        lit = '{qr: qr, qi: qi, dbz: dbz, ovf: ovf, due: 0};
        vecs++;
        if (m.qr !== qr || m.qi !== qi || m.dbz !== dbz || m.ovf !== ovf) begin
            miss++;
            $display("FAIL model_pin %h/%h: got re=%h im=%h dbz=%b ovf=%b, want re=%h im=%h dbz=%b ovf=%b",
                     n, d, m.qr, m.qi, m.dbz, m.ovf, qr, qi, dbz, ovf);
        end
        issue(n, d, lit);
    endtask

    task automatic wait_all();
        for (int i = 0; i < 200 && expq.size() != 0; i++) begin
            @(posedge Clk); #2;
        end
        if (expq.size() != 0) begin
            vecs++; miss++;
            $display("FAIL timeout: got %0d results pending, want 0", expq.size());
            expq.delete();
        end
    endtask

    logic [15:0] mv_n[5] = '{16'h03FB, 16'h7F80, 16'h80FF, 16'h0505, 16'hC0E0};
    logic [15:0] mv_d[5] = '{16'hFE07, 16'h0280, 16'hFF01, 16'h8000, 16'h0303};

    initial begin
        last = '{qr: 16'h0, qi: 16'h0, dbz: 1'b0, ovf: 1'b0, due: 0};
        Reset = 1'b0; Start = 1'b0; Dividend = 16'h0; Divisor = 16'h0;
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        @(posedge Clk); #2;

        issue_lit(16'h0402, 16'h0101, 16'h0300, 16'hFF00, 1'b0, 1'b0); wait_all();
        issue_lit(16'h0100, 16'h0300, 16'h0055, 16'h0000, 1'b0, 1'b0); wait_all();
        issue_lit(16'hFF00, 16'h0300, 16'hFFAB, 16'h0000, 1'b0, 1'b0); wait_all();
        issue_lit(16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 1'b0, 1'b1); wait_all();
        issue_lit(16'h8080, 16'h8080, 16'h0100, 16'h0000, 1'b0, 1'b0); wait_all();
        issue_lit(16'h1234, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0); wait_all();
        issue_lit(16'h7F7F, 16'h0100, 16'h7F00, 16'h7F00, 1'b0, 1'b0); wait_all();
        issue_lit(16'h8000, 16'h0100, 16'h8000, 16'h0000, 1'b0, 1'b0); wait_all();

        for (int i = 0; i < 5; i++) begin
            issue(mv_n[i], mv_d[i], model(mv_n[i], mv_d[i]));
            wait_all();
        end

        // Start pulse while busy must be ignored.
        issue(16'h0402, 16'h0101, model(16'h0402, 16'h0101));
        repeat (5) @(posedge Clk);
        #2 Start = 1'b1; Dividend = 16'h7F7F; Divisor = 16'h0001;
        @(posedge Clk); #2;
        vecs++;
        if (Busy !== 1'b1) begin
            miss++;
            $display("FAIL busy_flag: got Busy=%b, want 1", Busy);
        end
        Start = 1'b0;
        wait_all();
        repeat (30) @(posedge Clk);
        #2;

        // Start held through the Done cycle: back-to-back.
        issue(16'h03FB, 16'hFE07, model(16'h03FB, 16'hFE07));
        repeat (10) @(posedge Clk);
        #2 Start = 1'b1; Dividend = 16'hFF00; Divisor = 16'h0300;
        for (int i = 0; i < 100 && Done !== 1'b1; i++) begin
            @(posedge Clk); #2;
        end
        push_exp(model(16'hFF00, 16'h0300));
        @(posedge Clk); #2;
        Start = 1'b0;
        wait_all();

        // Reset during DIV aborts with no Done.
        issue(16'h0100, 16'h0300, model(16'h0100, 16'h0300));
        repeat (11) @(posedge Clk);
        #2 Reset = 1'b0;
        expq.delete();
        last = '{qr: 16'h0, qi: 16'h0, dbz: 1'b0, ovf: 1'b0, due: 0};
        repeat (3) @(posedge Clk);
        #2 Reset = 1'b1;
        repeat (40) @(posedge Clk);
        #2;
        issue_lit(16'h0402, 16'h0101, 16'h0300, 16'hFF00, 1'b0, 1'b0); wait_all();

        repeat (5) @(posedge Clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish by 500000, want finish");
        $fatal(1, "watchdog");
    end
endmodule
